// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: packs LE 32-bit words, writes them into
// instruction memory with the core held, then releases the core and steps the pc.
module imem_loader #(
  parameter int ADDR_W      = 2,
  parameter int STEP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              core_hold,
  output logic [ADDR_W-1:0] pc_drive,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count
);
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((2**ADDR_W) - 1);
  localparam logic [SW-1:0]     LAST_STEP = SW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_RUN} state_t;
  state_t r_state, w_next;

  logic [1:0]        r_idx;
  logic [23:0]       r_asm;   // bytes 0..2; byte 3 goes straight into the write word
  logic [31:0]       r_wdata;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_wcnt;
  logic [ADDR_W-1:0] r_pc;
  logic [SW-1:0]     r_step;

  logic w_accept, w_load;
  assign w_accept = (r_state == S_COLLECT) && byte_valid;
  assign w_load   = start && ((r_state == S_IDLE) || (r_state == S_RUN));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_COLLECT;
      S_COLLECT: if (w_accept && (r_idx == 2'd3)) w_next = S_WRITE;
      S_WRITE:   w_next = (r_addr == LAST_ADDR) ? S_RUN : S_COLLECT;
      S_RUN:     if (start) w_next = S_COLLECT;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx   <= '0;
      r_asm   <= '0;
      r_wdata <= '0;
      r_addr  <= '0;
      r_wcnt  <= '0;
      r_pc    <= '0;
      r_step  <= '0;
    end else begin
      if (w_load) begin
        r_idx  <= '0;
        r_addr <= '0;
        r_wcnt <= '0;
        r_pc   <= '0;
        r_step <= '0;
      end
      if (w_accept) begin
        for (int i = 0; i < 3; i++)
          if (r_idx == 2'(i)) r_asm[8*i +: 8] <= byte_in;
        if (r_idx == 2'd3) r_wdata <= {byte_in, r_asm};
        r_idx <= r_idx + 2'd1;  // wraps to 0 ready for the next word
      end
      if (r_state == S_WRITE) begin
        r_wcnt <= r_wcnt + (ADDR_W+1)'(1);
        if (r_addr != LAST_ADDR) r_addr <= r_addr + ADDR_W'(1);
        r_pc   <= '0;
        r_step <= '0;
      end
      // Each pc value is held STEP_CYCLES cycles; wraps naturally at DEPTH.
      if ((r_state == S_RUN) && !start) begin
        if (r_step == LAST_STEP) begin
          r_step <= '0;
          r_pc   <= r_pc + ADDR_W'(1);
        end else begin
          r_step <= r_step + SW'(1);
        end
      end
    end
  end

  assign byte_ready = (r_state == S_COLLECT);
  assign im_we      = (r_state == S_WRITE);
  assign im_addr    = r_addr;
  assign im_wdata   = r_wdata;
  assign core_hold  = (r_state != S_RUN);
  assign done       = (r_state == S_RUN);
  assign busy       = (r_state == S_COLLECT) || (r_state == S_WRITE);
  assign pc_drive   = r_pc;
  assign word_count = r_wcnt;
endmodule
